ctrl_decode_stage: RTL
======================

Name: ctrl_decode_stage

Overview:
- Registered successor to the combinational decode controller for the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX registers.
- Decodes the ID instruction into the control bundle and registers it into the ID/EX control register, with stall and flush support.
- Adds a parametrised interrupt front end: NUM_IRQ edge-latched, maskable sources with fixed priority, trap injection and a one-hot acknowledge.
- Counts illegal-instruction exceptions.

Parameters:
- NUM_IRQ, 4, number of external interrupt sources (1..16).
- IRQ_ID_W, 4, width of the encoded interrupt id; must satisfy 2^IRQ_ID_W >= NUM_IRQ.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  the ID instruction is real (not a bubble).
- instruction  in  32  the ID-stage instruction word.
- kernel_mode  in  1  PC[31] of the ID instruction; 1 suppresses IRQ injection.
- stall  in  1  hold the ID/EX control register.
- flush  in  1  load a bubble into the ID/EX control register.
- irq_req  in  NUM_IRQ  level interrupt requests.
- irq_mask  in  NUM_IRQ  1 = source enabled.
- ex_valid  out  1  the registered bundle is a real instruction or trap.
- ex_reg_dst  out  2  registered RegDst.
- ex_reg_wr  out  1  registered RegWr.
- ex_alusrc1  out  1  registered ALUSrc1.
- ex_alusrc2  out  1  registered ALUSrc2.
- ex_alufun  out  6  registered ALUFun.
- ex_sign  out  1  registered Sign.
- ex_mem_wr  out  1  registered MemWr.
- ex_mem_rd  out  1  registered MemRd.
- ex_mem_to_reg  out  2  registered MemToReg.
- ex_ext_op  out  1  registered EXTOp.
- ex_lu_op  out  1  registered LUOp.
- ex_is_j  out  1  registered jump flag.
- ex_is_branch  out  1  registered branch flag.
- ex_trap  out  2  00 none, 01 irq, 10 exception.
- ex_irq_id  out  IRQ_ID_W  id of the injected interrupt; valid when ex_trap=01.
- irq_pending  out  NUM_IRQ  pending latch contents.
- irq_ack  out  NUM_IRQ  one-cycle one-hot acknowledge.
- except_cnt  out  CNT_W  saturating exception count.

Behaviour:
- Reset (async, reset=0): all ex_* outputs 0, irq_pending 0, irq_ack 0, except_cnt 0. The previous-cycle copy of irq_req is cleared to 0, so a request high at reset release is seen as an edge.
- Pending latch, per bit i:
  - sets on a rising edge of irq_req[i], detected against the previous-cycle copy;
  - clears on irq_ack[i];
  - set and clear in the same cycle leaves the bit set; a new edge is never lost.
- Eligible = irq_pending & irq_mask. Winner = lowest-index eligible bit.
- Injection condition = instr_valid & !kernel_mode & !stall & !flush & (eligible != 0).
  - When it holds, the ID instruction is replaced by an IRQ trap.
  - irq_ack pulses the winner's bit for exactly one cycle, coincident with the register load.
- Illegal instruction: any opcode/funct outside the supported set, evaluated only when no IRQ is injected.
  - Produces an exception trap regardless of kernel_mode.
- Supported set:
  - R-type funct: 00,02,03,08,09,20-27,2a.
  - Opcodes: 01,02,03,04,05,06,07,08,09,0a,0b,0c,0d,0f,23,2b.
- Trap bundle (irq or exception): reg_dst=3, reg_wr=1, mem_to_reg=2; every other control bit 0 and alufun=100000; ex_trap per cause. ex_irq_id=winner for an irq trap, else 0.
- Legal bundle: decoded from the ctrl_pkg table:
  - ALUFun: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
  - nop decodes as sll with reg_wr=1.
- Register update priority at each clk: flush > stall > load.
  - flush: all ex_* = 0 (bubble); pending latch untouched; no ack.
  - stall: all ex_* hold; no ack; no count.
  - load: bundle registered; ex_valid=instr_valid. With instr_valid=0, everything except ex_valid is loaded as 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- except_cnt increments by 1 on every load of an exception trap; saturates at all-ones.
- Simultaneous IRQ and illegal instruction: the IRQ wins; the exception is re-raised when the instruction is refetched.
- Masking a pending source only blocks injection; the pending bit is not cleared.

Decomposition:
- ctrl_pkg holds:
  - ALUFun code localparams;
  - trap encodings;
  - opcode/funct constants;
  - a decode function from instruction to the control bundle (a packed struct typedef).
- One sub-module, irq_prio_latch, containing edge detect, pending, mask and priority encode, parametrised by NUM_IRQ.

Test Plan:
- Reset released, instruction=0x00851020 (add), instr_valid=1 -> next cycle ex_reg_dst=0, ex_reg_wr=1, ex_alufun=000000, ex_sign=1, ex_trap=00, ex_valid=1.
- irq_req=0b0110, mask=0b1111, kernel_mode=0 -> irq_ack=0b0010 one cycle, ex_trap=01, ex_irq_id=1, ex_reg_dst=3, ex_mem_to_reg=2; the next instruction injects with ack=0b0100.
- IRQ pending with kernel_mode=1, then kernel_mode=0 -> no ack while in kernel mode; ack on the first kernel_mode=0 load.
- IRQ pending with stall=1 for 3 cycles, then flush=1 for 1 cycle -> no ack and ex_* frozen then zeroed; injection on the next clean load.
- instruction=0xFC000000 loaded 300 times with CNT_W=8 -> ex_trap=10 each time; except_cnt saturates at 255.
- reset asserted mid-stall with pending=0b1000 -> all outputs and pending 0 immediately, asynchronously.

Source files
------------

// File: rtl/ctrl_decode_stage_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_decode_stage_pkg
// Shared definitions for the registered ID-stage decode controller:
//   - ALUFun operation codes
//   - RegDst / MemToReg selector encodings
//   - trap cause encodings driven on ex_trap
//   - MIPS opcode / funct constants of the supported instruction set
//   - the packed control bundle and the instruction decode function
// ----------------------------------------------------------------------------
package ctrl_decode_stage_pkg;

    // ALUFun codes
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    // Destination register select: rd, rt, $ra, exception return reg ($k0)
    localparam logic [1:0] RD_RD = 2'd0;
    localparam logic [1:0] RD_RT = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;
    localparam logic [1:0] RD_XP = 2'd3;

    // Write-back source select: memory, PC+4 (link)
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // Trap causes
    localparam logic [1:0] TRAP_NONE = 2'b00;
    localparam logic [1:0] TRAP_IRQ  = 2'b01;
    localparam logic [1:0] TRAP_EXC  = 2'b10;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       reg_wr;
        logic       alusrc1;
        logic       alusrc2;
        logic [5:0] alufun;
        logic       sign;
        logic       mem_wr;
        logic       mem_rd;
        logic [1:0] mem_to_reg;
        logic       ext_op;
        logic       lu_op;
        logic       is_j;
        logic       is_branch;
    } ctrl_t;

    typedef struct packed {
        logic  illegal;
        ctrl_t ctrl;
    } decode_t;

    // Bundle shared by IRQ and exception traps: link PC+4 into $k0.
    function automatic ctrl_t trap_ctrl();
        ctrl_t c;
        c            = '0;
        c.reg_dst    = RD_XP;
        c.reg_wr     = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.alufun     = ALU_SLL;
        return c;
    endfunction

    // Sign is set for every operation except the explicitly unsigned ones
    // (addu, subu, addiu, sltiu). Branch/load/store offsets sign-extend.
    function automatic decode_t decode_instr(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        decode_t d;
        d             = '0;
        d.ctrl.sign   = 1'b1;
        d.ctrl.alufun = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                d.ctrl.reg_dst = RD_RD;
                d.ctrl.reg_wr  = 1'b1;
                case (funct)
                    FN_SLL:  begin d.ctrl.alufun = ALU_SLL; d.ctrl.alusrc1 = 1'b1; end
                    FN_SRL:  begin d.ctrl.alufun = ALU_SRL; d.ctrl.alusrc1 = 1'b1; end
                    FN_SRA:  begin d.ctrl.alufun = ALU_SRA; d.ctrl.alusrc1 = 1'b1; end
                    FN_JR:   begin d.ctrl.reg_wr = 1'b0; d.ctrl.is_j = 1'b1; end
                    FN_JALR: begin d.ctrl.is_j = 1'b1; d.ctrl.mem_to_reg = M2R_PC; end
                    FN_ADD:  d.ctrl.alufun = ALU_ADD;
                    FN_ADDU: d.ctrl.sign = 1'b0;
                    FN_SUB:  d.ctrl.alufun = ALU_SUB;
                    FN_SUBU: begin d.ctrl.alufun = ALU_SUB; d.ctrl.sign = 1'b0; end
                    FN_AND:  d.ctrl.alufun = ALU_AND;
                    FN_OR:   d.ctrl.alufun = ALU_OR;
                    FN_XOR:  d.ctrl.alufun = ALU_XOR;
                    FN_NOR:  d.ctrl.alufun = ALU_NOR;
                    FN_SLT:  d.ctrl.alufun = ALU_LT;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                d.ctrl.is_branch = 1'b1;
                d.ctrl.ext_op    = 1'b1;
                case (opcode)
                    OP_REGIMM: d.ctrl.alufun = ALU_LTZ;
                    OP_BEQ:    d.ctrl.alufun = ALU_EQ;
                    OP_BNE:    d.ctrl.alufun = ALU_NEQ;
                    OP_BLEZ:   d.ctrl.alufun = ALU_LEZ;
                    default:   d.ctrl.alufun = ALU_GTZ;
                endcase
            end
            OP_J:   d.ctrl.is_j = 1'b1;
            OP_JAL: begin
                d.ctrl.is_j       = 1'b1;
                d.ctrl.reg_wr     = 1'b1;
                d.ctrl.reg_dst    = RD_RA;
                d.ctrl.mem_to_reg = M2R_PC;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                d.ctrl.reg_dst = RD_RT;
                d.ctrl.reg_wr  = 1'b1;
                d.ctrl.alusrc2 = 1'b1;
                d.ctrl.ext_op  = 1'b1;
                case (opcode)
                    OP_ADDIU: d.ctrl.sign = 1'b0;
                    OP_SLTI:  d.ctrl.alufun = ALU_LT;
                    OP_SLTIU: begin d.ctrl.alufun = ALU_LT; d.ctrl.sign = 1'b0; end
                    OP_ANDI:  begin d.ctrl.alufun = ALU_AND; d.ctrl.ext_op = 1'b0; end
                    OP_ORI:   begin d.ctrl.alufun = ALU_OR; d.ctrl.ext_op = 1'b0; end
                    OP_LUI:   begin d.ctrl.lu_op = 1'b1; d.ctrl.ext_op = 1'b0; end
                    OP_LW:    begin d.ctrl.mem_rd = 1'b1; d.ctrl.mem_to_reg = M2R_MEM; end
                    default:  d.ctrl.alufun = ALU_ADD;
                endcase
            end
            OP_SW: begin
                d.ctrl.alusrc2 = 1'b1;
                d.ctrl.ext_op  = 1'b1;
                d.ctrl.mem_wr  = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.ctrl = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_irq_prio_latch.sv
// ----------------------------------------------------------------------------
// ctrl_decode_stage_irq_prio_latch
// Edge-latched, maskable interrupt front end with fixed (lowest index wins)
// priority.
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   irq_req_i    level requests; a rising edge sets the pending bit
//   irq_mask_i   1 = source may be injected
//   ack_i        one-hot clear of the pending bit being serviced
//   pending_o    pending latch contents
//   any_o        at least one source is pending and enabled
//   winner_id_o  encoded index of the winning source
//   winner_oh_o  one-hot winning source
// ----------------------------------------------------------------------------
module ctrl_decode_stage_irq_prio_latch #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [NUM_IRQ-1:0]  irq_req_i,
    input  logic [NUM_IRQ-1:0]  irq_mask_i,
    input  logic [NUM_IRQ-1:0]  ack_i,
    output logic [NUM_IRQ-1:0]  pending_o,
    output logic                any_o,
    output logic [IRQ_ID_W-1:0] winner_id_o,
    output logic [NUM_IRQ-1:0]  winner_oh_o
);

    logic [NUM_IRQ-1:0] req_prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] eligible;

    // A fresh edge overrides a same-cycle acknowledge so it is never lost.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        assign pend_d[gi] = (pend_q[gi] & ~ack_i[gi]) | (irq_req_i[gi] & ~req_prev_q[gi]);
    end

    // req_prev_q clears on reset so a request already high at release
    // is treated as a new edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            req_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            req_prev_q <= irq_req_i;
            pend_q     <= pend_d;
        end
    end

    assign eligible  = pend_q & irq_mask_i;
    assign any_o     = |eligible;
    assign pending_o = pend_q;

    always_comb begin
        logic found;
        found       = 1'b0;
        winner_id_o = '0;
        winner_oh_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !found) begin
                found          = 1'b1;
                winner_id_o    = IRQ_ID_W'(i);
                winner_oh_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ----------------------------------------------------------------------------
// ctrl_decode_stage
// Registered ID-stage decode controller for the 5-stage MIPS pipeline.
// Decodes the ID instruction into the control bundle and loads it into the
// ID/EX control register (flush > stall > load), replacing it with an IRQ or
// illegal-instruction trap where required.
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   instr_valid_i            ID instruction is real (not a bubble)
//   instruction_i            ID instruction word
//   kernel_mode_i            PC[31] of the ID instruction; blocks IRQ injection
//   stall_i, flush_i         hold / bubble the ID/EX control register
//   irq_req_i, irq_mask_i    interrupt requests and enables
//   ex_*_o                   registered control bundle, trap cause and irq id
//   irq_pending_o            pending latch contents
//   irq_ack_o                one-cycle one-hot acknowledge, shown with the
//                            trap bundle it produced
//   except_cnt_o             saturating illegal-instruction count
// ----------------------------------------------------------------------------
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                instr_valid_i,
    input  logic [31:0]         instruction_i,
    input  logic                kernel_mode_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [NUM_IRQ-1:0]  irq_req_i,
    input  logic [NUM_IRQ-1:0]  irq_mask_i,
    output logic                ex_valid_o,
    output logic [1:0]          ex_reg_dst_o,
    output logic                ex_reg_wr_o,
    output logic                ex_alusrc1_o,
    output logic                ex_alusrc2_o,
    output logic [5:0]          ex_alufun_o,
    output logic                ex_sign_o,
    output logic                ex_mem_wr_o,
    output logic                ex_mem_rd_o,
    output logic [1:0]          ex_mem_to_reg_o,
    output logic                ex_ext_op_o,
    output logic                ex_lu_op_o,
    output logic                ex_is_j_o,
    output logic                ex_is_branch_o,
    output logic [1:0]          ex_trap_o,
    output logic [IRQ_ID_W-1:0] ex_irq_id_o,
    output logic [NUM_IRQ-1:0]  irq_pending_o,
    output logic [NUM_IRQ-1:0]  irq_ack_o,
    output logic [CNT_W-1:0]    except_cnt_o
);

    decode_t             dec;
    ctrl_t               ctrl_d, ctrl_q;
    logic [1:0]          trap_d, trap_q;
    logic [IRQ_ID_W-1:0] irq_id_d, irq_id_q;
    logic [NUM_IRQ-1:0]  ack_d, ack_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic                valid_q;
    logic                load;
    logic                inject;
    logic                except_raise;
    logic                irq_any;
    logic [IRQ_ID_W-1:0] winner_id;
    logic [NUM_IRQ-1:0]  winner_oh;
    logic                unused_instr_bits;

    // Only opcode and funct steer decode; the register fields pass through
    // the datapath.
    assign unused_instr_bits = ^instruction_i[25:6];
    assign dec = decode_instr(instruction_i[31:26], instruction_i[5:0]);

    ctrl_decode_stage_irq_prio_latch #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_ID_W (IRQ_ID_W)
    ) u_irq (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .irq_req_i   (irq_req_i),
        .irq_mask_i  (irq_mask_i),
        .ack_i       (ack_d),
        .pending_o   (irq_pending_o),
        .any_o       (irq_any),
        .winner_id_o (winner_id),
        .winner_oh_o (winner_oh)
    );

    assign load         = !flush_i && !stall_i;
    assign inject       = instr_valid_i && !kernel_mode_i && load && irq_any;
    // An injected IRQ pre-empts the exception; the instruction is refetched
    // after the handler and re-raises it then.
    assign except_raise = instr_valid_i && dec.illegal && !inject;
    // Acknowledge clears the pending bit at the same edge the trap loads.
    assign ack_d        = inject ? winner_oh : '0;

    always_comb begin
        ctrl_d   = '0;
        trap_d   = TRAP_NONE;
        irq_id_d = '0;
        if (inject) begin
            ctrl_d   = trap_ctrl();
            trap_d   = TRAP_IRQ;
            irq_id_d = winner_id;
        end else if (except_raise) begin
            ctrl_d = trap_ctrl();
            trap_d = TRAP_EXC;
        end else if (instr_valid_i) begin
            ctrl_d = dec.ctrl;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load && except_raise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            trap_q   <= TRAP_NONE;
            irq_id_q <= '0;
            ack_q    <= '0;
            cnt_q    <= '0;
        end else begin
            ack_q <= ack_d;
            cnt_q <= cnt_d;
            if (flush_i) begin
                valid_q  <= 1'b0;
                ctrl_q   <= '0;
                trap_q   <= TRAP_NONE;
                irq_id_q <= '0;
            end else if (!stall_i) begin
                valid_q  <= instr_valid_i;
                ctrl_q   <= ctrl_d;
                trap_q   <= trap_d;
                irq_id_q <= irq_id_d;
            end
        end
    end

    assign ex_valid_o      = valid_q;
    assign ex_reg_dst_o    = ctrl_q.reg_dst;
    assign ex_reg_wr_o     = ctrl_q.reg_wr;
    assign ex_alusrc1_o    = ctrl_q.alusrc1;
    assign ex_alusrc2_o    = ctrl_q.alusrc2;
    assign ex_alufun_o     = ctrl_q.alufun;
    assign ex_sign_o       = ctrl_q.sign;
    assign ex_mem_wr_o     = ctrl_q.mem_wr;
    assign ex_mem_rd_o     = ctrl_q.mem_rd;
    assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
    assign ex_ext_op_o     = ctrl_q.ext_op;
    assign ex_lu_op_o      = ctrl_q.lu_op;
    assign ex_is_j_o       = ctrl_q.is_j;
    assign ex_is_branch_o  = ctrl_q.is_branch;
    assign ex_trap_o       = trap_q;
    assign ex_irq_id_o     = irq_id_q;
    assign irq_ack_o       = ack_q;
    assign except_cnt_o    = cnt_q;

endmodule
